// File: rtl/dip_led_serializer_if.sv
// Parallel LED/aux request side and serial 74HC595 chain side of dip_led_serializer.
interface dip_led_serializer_if #(
    parameter int unsigned LED_BITS = 16,
    parameter int unsigned AUX_BITS = 8
);
    logic [LED_BITS-1:0] i_LED16;
    logic [AUX_BITS-1:0] i_Aux8;
    logic                i_Valid;
    logic                o_Ready;
    logic                i_Auto;
    logic                o_SData;
    logic                o_SCLK;
    logic                o_Latch;
    logic                o_FrameDone;

    modport master (
        output i_LED16, i_Aux8, i_Valid, i_Auto,
        input  o_Ready, o_SData, o_SCLK, o_Latch, o_FrameDone
    );

    modport slave (
        input  i_LED16, i_Aux8, i_Valid, i_Auto,
        output o_Ready, o_SData, o_SCLK, o_Latch, o_FrameDone
    );
endinterface

// File: rtl/dip_led_serializer.sv
// Shifts a {aux, led} frame MSB-first into an external 74HC595 chain and strobes its latch,
// with one-shot requests or continuous refresh of the held frame.
module dip_led_serializer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned LED_BITS  = 16,
    parameter int unsigned AUX_BITS  = 8,
    parameter int unsigned FRAME_LEN = LED_BITS + AUX_BITS
) (
    input  logic              i_CLK,
    input  logic              i_RESET,
    dip_led_serializer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(FRAME_LEN - 1);

    state_t               state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [4:0]           bit_q, bit_d;
    logic [FRAME_LEN-1:0] shadow_q, shadow_d;
    logic                 loaded_q, loaded_d;
    logic                 done_q, done_d;
    logic                 div_end;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        div_end  = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (bus.i_Valid) begin
                    shadow_d = {bus.i_Aux8, bus.i_LED16};
                    loaded_d = 1'b1;
                    state_d  = SHIFT_LO;
                end else if (bus.i_Auto && loaded_q) begin
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data is driven from the bit index, which only advances on the HI->LO edge,
    // so o_SData cannot move while SCLK is high.
    always_comb begin
        bus.o_Ready     = (state_q == IDLE) && !i_RESET;
        bus.o_SCLK      = (state_q == SHIFT_HI);
        bus.o_Latch     = (state_q == LATCH);
        bus.o_FrameDone = done_q;
        bus.o_SData     = 1'b0;
        if (state_q == SHIFT_LO || state_q == SHIFT_HI)
            bus.o_SData = shadow_q[BIT_LAST - bit_q];
    end
endmodule
